// File: rtl/m_immexp_pkg.sv
// Shared constants for the midgetv immediate expander / Q shift sequencer:
// immediate-type codes, opcode field values and sequencer state encoding.
package m_immexp_pkg;

    localparam logic [2:0] IT_U    = 3'b000;
    localparam logic [2:0] IT_J    = 3'b001;
    localparam logic [2:0] IT_B    = 3'b010;
    localparam logic [2:0] IT_S    = 3'b100;
    localparam logic [2:0] IT_I    = 3'b101;
    localparam logic [2:0] IT_ILL  = 3'b110;
    localparam logic [2:0] IT_PASS = 3'b111;

    // INSTR[6:2] opcode values
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_CUSTOM = 5'b00010;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shst_t;

endpackage

// File: rtl/m_immexp_dec.sv
// Combinational immediate-type decode and Q-source (F) generation:
// a sign-extended RISC-V immediate, the ALU output B, or zero for illegal opcodes.
module m_immexp_dec
    import m_immexp_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] B,
    input  logic [31:0]     INSTR,
    input  logic            sa11,
    output logic [2:0]      itype,
    output logic [XLEN-1:0] F
);

    logic       sgn;
    logic [4:0] opc;
    logic [1:0] unused_len;

    assign sgn        = INSTR[31];
    assign opc        = INSTR[6:2];
    assign unused_len = INSTR[1:0];

    always_comb begin
        itype = IT_ILL;
        if (!sa11) begin
            itype = IT_PASS;
        end else begin
            case (opc)
                OPC_LOAD, OPC_OPIMM, OPC_JALR,
                OPC_OP, OPC_SYSTEM, OPC_CUSTOM: itype = IT_I;
                OPC_STORE:                      itype = IT_S;
                OPC_BRANCH:                     itype = IT_B;
                OPC_JAL:                        itype = IT_J;
                OPC_AUIPC, OPC_LUI:             itype = IT_U;
                default:                        itype = IT_ILL;
            endcase
        end
    end

    // U-type replicates bit 31 over XLEN-31 positions so XLEN=32 needs no zero-width replication
    always_comb begin
        F = '0;
        case (itype)
            IT_I:    F = {{(XLEN-12){sgn}}, INSTR[31:20]};
            IT_S:    F = {{(XLEN-12){sgn}}, INSTR[31:25], INSTR[11:7]};
            IT_B:    F = {{(XLEN-12){sgn}}, INSTR[7], INSTR[30:25], INSTR[11:8], 1'b0};
            IT_J:    F = {{(XLEN-20){sgn}}, INSTR[19:12], INSTR[20], INSTR[30:21], 1'b0};
            IT_U:    F = {{(XLEN-31){sgn}}, INSTR[30:12], 12'b0};
            IT_PASS: F = B;
            default: F = '0;
        endcase
    end

endmodule

// File: rtl/m_immexp_q_shseq.sv
// Working register Q (ADR_O) with zero flag and a multi-cycle shift sequencer.
// Define MIDGETV_QSHIFT4_EN to shift by 4 per cycle while at least 4 positions remain.
module m_immexp_q_shseq
    import m_immexp_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned CNTW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] B,
    input  logic [31:0]     INSTR,
    input  logic            sa11,
    input  logic            sa14,
    input  logic            enaQ,
    input  logic            shstart,
    input  logic [CNTW-1:0] shamt,
    input  logic            shleft,
    input  logic            sharith,
    output logic [XLEN-1:0] ADR_O,
    output logic            rzcy,
    output logic            shbusy,
    output logic            shdone,
    output logic [2:0]      itype
);

    shst_t           state;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] f;
    logic [XLEN-1:0] q_sh;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] step;
    logic            dir_left;
    logic            arith;
    logic            fill;
    logic            clr;

    m_immexp_dec #(.XLEN(XLEN)) u_dec (
        .B     (B),
        .INSTR (INSTR),
        .sa11  (sa11),
        .itype (itype),
        .F     (f)
    );

    assign clr  = enaQ & sa14;
    assign fill = arith & q[XLEN-1];

`ifdef MIDGETV_QSHIFT4_EN
    always_comb begin
        step = CNTW'(1);
        q_sh = dir_left ? {q[XLEN-2:0], 1'b0} : {fill, q[XLEN-1:1]};
        if (cnt >= CNTW'(4)) begin
            step = CNTW'(4);
            q_sh = dir_left ? {q[XLEN-5:0], 4'b0} : {{4{fill}}, q[XLEN-1:4]};
        end
    end
`else
    assign step = CNTW'(1);
    assign q_sh = dir_left ? {q[XLEN-2:0], 1'b0} : {fill, q[XLEN-1:1]};
`endif

    // Q, zero flag, count and sequencer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            q        <= '0;
            rzcy     <= 1'b0;
            cnt      <= '0;
            dir_left <= 1'b0;
            arith    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr) begin
                        q    <= '0;
                        rzcy <= 1'b0;
                    end else if (shstart) begin
                        cnt      <= shamt;
                        dir_left <= shleft;
                        arith    <= sharith;
                        state    <= (shamt != '0) ? ST_SHIFT : ST_DONE;
                    end else if (enaQ) begin
                        q    <= f;
                        rzcy <= (B != '0);
                    end
                end
                ST_SHIFT: begin
                    if (clr) begin
                        q     <= '0;
                        rzcy  <= 1'b0;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        q    <= q_sh;
                        rzcy <= (q_sh != '0);
                        cnt  <= cnt - step;
                        if (cnt == step) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (clr) begin
                        q    <= '0;
                        rzcy <= 1'b0;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Status flags are pure decodes of the state register
    assign shbusy = (state == ST_SHIFT) | (state == ST_DONE);
    assign shdone = (state == ST_DONE);
    assign ADR_O  = q;

endmodule

// File: tb/tb_m_immexp_q_shseq.sv
// Randomized self-checking bench for m_immexp_q_shseq (XLEN=32) against a
// whole-operation reference model: immediates from format rules, shifts as single operators.
`timescale 1ns/1ps
module tb_m_immexp_q_shseq;

    localparam int unsigned XLEN = 32;
    localparam int unsigned CNTW = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] B = '0;
    logic [31:0]     INSTR = '0;
    logic            sa11 = 1'b0;
    logic            sa14 = 1'b0;
    logic            enaQ = 1'b0;
    logic            shstart = 1'b0;
    logic [CNTW-1:0] shamt = '0;
    logic            shleft = 1'b0;
    logic            sharith = 1'b0;
    logic [XLEN-1:0] ADR_O;
    logic            rzcy;
    logic            shbusy;
    logic            shdone;
    logic [2:0]      itype;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [31:0] q_m = '0;
    logic        rz_m = 1'b0;

    always #5 clk = ~clk;

    m_immexp_q_shseq #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .B       (B),
        .INSTR   (INSTR),
        .sa11    (sa11),
        .sa14    (sa14),
        .enaQ    (enaQ),
        .shstart (shstart),
        .shamt   (shamt),
        .shleft  (shleft),
        .sharith (sharith),
        .ADR_O   (ADR_O),
        .rzcy    (rzcy),
        .shbusy  (shbusy),
        .shdone  (shdone),
        .itype   (itype)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] m_itype(input logic s11, input logic [31:0] ins);
        logic [4:0] op;
        op = ins[6:2];
        if (!s11) return 3'b111;
        case (op)
            5'b00000, 5'b00100, 5'b11001, 5'b01100, 5'b11100, 5'b00010: return 3'b101;
            5'b01000: return 3'b100;
            5'b11000: return 3'b010;
            5'b11011: return 3'b001;
            5'b00101, 5'b01101: return 3'b000;
            default: return 3'b110;
        endcase
    endfunction

    function automatic logic [31:0] m_f(input logic s11, input logic [31:0] ins, input logic [31:0] b);
        logic signed [31:0] v;
        case (m_itype(s11, ins))
            3'b111:  v = b;
            3'b101:  v = 32'($signed(ins[31:20]));
            3'b100:  v = 32'($signed({ins[31:25], ins[11:7]}));
            3'b010:  v = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'b001:  v = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'b000:  v = {ins[31:12], 12'h000};
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic do_load(input logic s11, input logic [31:0] ins, input logic [31:0] b);
        sa11 = s11; INSTR = ins; B = b; enaQ = 1'b1; sa14 = 1'b0;
        #1;
        chk("itype", 64'(itype), 64'(m_itype(s11, ins)));
        tick();
        enaQ = 1'b0;
        q_m  = m_f(s11, ins, b);
        rz_m = (b != 32'd0);
        chk("load_q", 64'(ADR_O), 64'(q_m));
        chk("load_rz", 64'(rzcy), 64'(rz_m));
    endtask

    task automatic do_clear();
        enaQ = 1'b1; sa14 = 1'b1;
        tick();
        enaQ = 1'b0; sa14 = 1'b0;
        q_m = '0; rz_m = 1'b0;
        chk("clr_q", 64'(ADR_O), 64'(q_m));
        chk("clr_rz", 64'(rzcy), 64'(rz_m));
    endtask

    task automatic do_shift(input int n, input logic left, input logic ar);
        logic [31:0] res;
        logic        rz_exp;
        int          exp_cyc;
        int          cyc;
        int          dn;
        if (left) res = q_m << n;
        else if (ar) res = 32'($signed(q_m) >>> n);
        else res = q_m >> n;
        rz_exp = (n != 0) ? (res != 32'd0) : rz_m;
`ifdef MIDGETV_QSHIFT4_EN
        exp_cyc = n / 4 + n % 4 + 1;
`else
        exp_cyc = n + 1;
`endif
        shstart = 1'b1; shamt = CNTW'(n); shleft = left; sharith = ar; sa14 = 1'b0;
        tick();
        shstart = 1'b0;
        cyc = 0; dn = 0;
        while (shbusy && cyc < 200) begin
            cyc++;
            if (shdone) begin
                dn++;
                chk("sh_q", 64'(ADR_O), 64'(res));
                chk("sh_rz", 64'(rzcy), 64'(rz_exp));
            end
            // latched controls and stray enaQ/shstart must not disturb the sequence
            shleft  = 1'($urandom);
            sharith = 1'($urandom);
            if (cyc < exp_cyc) begin
                enaQ    = 1'($urandom);
                shstart = 1'($urandom);
                B       = $urandom;
            end else begin
                enaQ    = 1'b0;
                shstart = 1'b0;
            end
            tick();
        end
        enaQ = 1'b0; shstart = 1'b0;
        chk("sh_cycles", 64'(cyc), 64'(exp_cyc));
        chk("sh_done_cnt", 64'(dn), 64'd1);
        q_m  = res;
        rz_m = rz_exp;
    endtask

    initial begin
        logic [4:0]  opcs [12];
        logic [31:0] ins;
        int          op;
        int          seen_done;

        opcs = '{5'b00000, 5'b00100, 5'b11001, 5'b01100, 5'b11100, 5'b00010,
                 5'b01000, 5'b11000, 5'b11011, 5'b00101, 5'b01101, 5'b11111};

        #3;
        chk("rst_q", 64'(ADR_O), 64'd0);
        chk("rst_rz", 64'(rzcy), 64'd0);
        chk("rst_busy", 64'(shbusy), 64'd0);
        chk("rst_done", 64'(shdone), 64'd0);
        #9 rst_n = 1'b1;
        tick();

        // asynchronous reset mid-cycle
        do_load(1'b0, 32'h0, 32'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_q", 64'(ADR_O), 64'd0);
        chk("async_rst_rz", 64'(rzcy), 64'd0);
        #2 rst_n = 1'b1;
        q_m = '0; rz_m = 1'b0;
        tick();

        do_load(1'b1, 32'hFFF00093, 32'd0);
        chk("addi_m1", 64'(ADR_O), 64'hFFFFFFFF);
        do_load(1'b1, 32'h123452B7, 32'd0);
        chk("lui", 64'(ADR_O), 64'h12345000);
        do_load(1'b1, 32'h0000007F, 32'd5);
        chk("ill_q", 64'(ADR_O), 64'd0);
        chk("ill_rz", 64'(rzcy), 64'd1);

        do_load(1'b0, 32'h0, 32'h80000010);
        do_shift(4, 1'b0, 1'b1);
        chk("sra4", 64'(ADR_O), 64'hF8000001);

        do_shift(0, 1'b1, 1'b0);
        chk("zero_amt_q", 64'(ADR_O), 64'hF8000001);

        do_load(1'b0, 32'h0, 32'h00000001);
        do_shift(1, 1'b0, 1'b0);
        chk("zero_flag", 64'(rzcy), 64'd0);

        do_shift(31, 1'b1, 1'b0);
        do_load(1'b0, 32'h0, 32'h00000001);
        do_shift(31, 1'b1, 1'b0);
        chk("sll31", 64'(ADR_O), 64'h80000000);

        // abort on shift cycle 3
        do_load(1'b0, 32'h0, 32'h0F0F0F0F);
        shstart = 1'b1; shamt = CNTW'(20); shleft = 1'b0; sharith = 1'b0;
        tick();
        shstart = 1'b0;
        tick();
        tick();
        chk("abort_busy_pre", 64'(shbusy), 64'd1);
        enaQ = 1'b1; sa14 = 1'b1;
        tick();
        enaQ = 1'b0; sa14 = 1'b0;
        chk("abort_q", 64'(ADR_O), 64'd0);
        chk("abort_rz", 64'(rzcy), 64'd0);
        chk("abort_busy", 64'(shbusy), 64'd0);
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (shdone) seen_done++;
            tick();
        end
        chk("abort_no_done", 64'(seen_done), 64'd0);
        q_m = '0; rz_m = 1'b0;

        // reset during a shift
        do_load(1'b0, 32'h0, 32'h00F00000);
        shstart = 1'b1; shamt = CNTW'(10); shleft = 1'b1; sharith = 1'b0;
        tick();
        shstart = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midsh_rst_q", 64'(ADR_O), 64'd0);
        chk("midsh_rst_busy", 64'(shbusy), 64'd0);
        chk("midsh_rst_done", 64'(shdone), 64'd0);
        #2 rst_n = 1'b1;
        q_m = '0; rz_m = 1'b0;
        tick();

        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin
                    ins      = $urandom;
                    ins[6:2] = opcs[$urandom_range(0, 11)];
                    ins[1:0] = 2'b11;
                    do_load(1'($urandom), ins, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
                end
                1: begin
                    do_load(1'b0, 32'h0, $urandom);
                    do_shift(int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
                end
                2: do_clear();
                default: do_shift(int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/m_immexp_q_shseq.md
Name: m_immexp_q_shseq

Overview:
- Next-generation immediate expander, zero-finder and working register Q for midgetv.
- Generalised to XLEN 32 or 64.
- Adds a built-in multi-cycle shift sequencer on Q, so serial shifts no longer need repeated ALU passes.
- Sits between the ALU output B and ADR_O (the Q register, also used as the I/O address), in the same place in the datapath as the current Q.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- CNTW, $clog2(XLEN), width of the shift-amount and counter fields (derived; do not override).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset. Asynchronous, active-low.
- B  input  XLEN  ALU output.
- INSTR  input  32  current instruction word.
- sa11  input  1  immediate-expand select.
- sa14  input  1  clear Q; qualified by enaQ.
- enaQ  input  1  load/clear enable for Q.
- shstart  input  1  start-shift request; single-cycle strobe.
- shamt  input  CNTW  shift amount.
- shleft  input  1  1 = shift left, 0 = shift right.
- sharith  input  1  right shift replicates Q[XLEN-1]; ignored on left shifts.
- ADR_O  output  XLEN  Q register.
- rzcy  output  1  registered "Q-source nonzero" flag.
- shbusy  output  1  sequencer owns Q.
- shdone  output  1  one-cycle completion pulse.
- itype  output  3  decoded immediate type, for debug.

Behaviour:
- Reset (rst_n low, asynchronous): ADR_O=0, rzcy=0, state=IDLE, cnt=0, shbusy=0, shdone=0.
- itype decode (combinational) from {sa11, INSTR[6:2]}:
  - sa11=0 -> 111 (pass B).
  - I-type 101: Load 00000, OP-IMM 00100, JALR 11001, OP 01100, SYSTEM 11100, custom 00010.
  - S-type 100: 01000.
  - B-type 010: 11000.
  - J-type 001: 11011.
  - U-type 000: AUIPC 00101, LUI 01101.
  - Any other opcode -> 110 (illegal).
- Immediate F (combinational, XLEN wide): standard RISC-V formats, sign-extended from INSTR[31] to XLEN.
  - U-type: {sext(INSTR[31:12]), 12'b0}.
  - B-type and J-type: bit 0 = 0.
  - itype 111: F = B.
  - itype 110: F = 0.
- States: IDLE, SHIFT, DONE.
- IDLE, priority order:
  1. enaQ & sa14 -> Q=0, rzcy=0.
  2. else shstart -> cnt=shamt. Q unchanged. Go to SHIFT if shamt!=0, else DONE. enaQ is ignored in this cycle.
  3. else enaQ -> Q=F, rzcy=(B!=0). rzcy uses B even when F is an immediate.
- SHIFT:
  - Each cycle: Q shifts by 1 in the requested direction, cnt decrements, rzcy=(shifted Q!=0).
  - Left shift fills with 0. Right shift fills with 0, or with Q[XLEN-1] when sharith=1.
  - The cycle where cnt==1 performs the last shift and goes to DONE.
  - Latency: shamt=N completes in N SHIFT cycles plus 1 DONE cycle.
  - enaQ & sa14 aborts: Q=0, rzcy=0, go to IDLE, no shdone.
  - enaQ without sa14 is ignored. shstart is ignored.
- DONE: shdone=1 for exactly this cycle; Q holds; next state IDLE.
  - enaQ & sa14 in DONE clears Q; shdone still asserts.
  - shstart in DONE is ignored.
- shbusy = (state==SHIFT) | (state==DONE).
- shleft and sharith are latched at shstart; changes during SHIFT have no effect.
- shamt wider than XLEN is impossible by width. Maximum is XLEN-1.
- rst_n asserted mid-shift returns to the reset values immediately; no shdone.

Optional Feature:
- Macro MIDGETV_QSHIFT4_EN.
- Defined: each SHIFT cycle with cnt>=4 shifts by 4 and subtracts 4; otherwise shifts by 1. N=13 then takes 3+1 SHIFT cycles plus DONE.
- Undefined: 1 bit per cycle only; no 4-bit shifter logic is present.

Decomposition:
- Package m_immexp_pkg holds:
  - itype localparams: IT_U, IT_J, IT_B, IT_S, IT_I, IT_ILL, IT_PASS.
  - Opcode constants.
  - Shift-state enum encoding.
- One sub-module, m_immexp_dec: the combinational itype decode and F generation, parametrised by XLEN.
- The top holds Q, rzcy, cnt and the FSM.

Test Plan:
1. Reset sequencing: rst_n=0 while Q=0xDEADBEEF -> ADR_O=0 and rzcy=0 asynchronously, before the next clk edge.
2. Immediate load, XLEN=32: sa11=1, enaQ=1.
   - INSTR=0xFFF00093 (addi, imm -1) -> ADR_O=0xFFFFFFFF.
   - INSTR=0x123452B7 (LUI) -> ADR_O=0x12345000.
   - With XLEN=64, the LUI case gives ADR_O=0x0000000012345000.
   - INSTR=0x80000037 (LUI, bit 31 set), XLEN=64 -> ADR_O=0xFFFFFFFF80000000.
3. Illegal opcode and B flag: sa11=1, INSTR[6:2]=11111, B=5 -> ADR_O=0, rzcy=1.
4. Arithmetic right shift: Q=0x80000010, shstart, shamt=4, sharith=1 -> shbusy for 5 cycles, then ADR_O=0xF8000001, shdone high 1 cycle; with MIDGETV_QSHIFT4_EN, 2 busy cycles.
5. Zero-amount and abort:
   - shamt=0 -> shdone on the next cycle, Q unchanged.
   - shamt=20, then enaQ=1 & sa14=1 on shift cycle 3 -> Q=0, IDLE, no shdone.
6. Zero flag through shift: Q=1, shleft=0, shamt=1 -> ADR_O=0, rzcy=0 at DONE.
